// File: rtl/mul_seq_pkg.sv
// Shared types and sizing for the shift-add sequential multiplier.
package mul_seq_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;
    localparam logic [CNT_W-1:0] CNT_ONE  = 5'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/CLA_32bit.sv
// 32-bit adder built from eight 4-bit carry-lookahead groups chained group to group.
// sel=1 inverts b so the caller can subtract by also driving Cin=1.
module CLA_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sel,
    input  logic        Cin,
    output logic [31:0] sum,
    output logic        Cout
);

    logic [31:0] b_eff;
    logic [31:0] p;
    logic [31:0] g;
    logic [31:0] c;

    assign b_eff = b ^ {32{sel}};
    assign p     = a ^ b_eff;
    assign g     = a & b_eff;

    // Lookahead carries inside each 4-bit group, group carry-out feeds the next group.
    always_comb begin
        logic       carry;
        logic [3:0] gp;
        logic [3:0] pp;
        carry = Cin;
        c     = 32'd0;
        gp    = 4'd0;
        pp    = 4'd0;
        for (int k = 0; k < 8; k++) begin
            gp = g[4*k +: 4];
            pp = p[4*k +: 4];
            c[4*k]     = carry;
            c[4*k + 1] = gp[0] | (pp[0] & carry);
            c[4*k + 2] = gp[1] | (pp[1] & gp[0]) | (pp[1] & pp[0] & carry);
            c[4*k + 3] = gp[2] | (pp[2] & gp[1]) | (pp[2] & pp[1] & gp[0])
                       | (pp[2] & pp[1] & pp[0] & carry);
            carry      = gp[3] | (pp[3] & gp[2]) | (pp[3] & pp[2] & gp[1])
                       | (pp[3] & pp[2] & pp[1] & gp[0])
                       | (pp[3] & pp[2] & pp[1] & pp[0] & carry);
        end
        Cout = carry;
        sum  = p ^ c;
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential 32x32 -> 32 shift-add multiplier with optional accumulate (MUL/MLA),
// one multiplier bit per cycle, optional early exit once the remaining multiplier is zero.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              accumulate,
    input  logic              flush,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] op_c,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_n,
    output logic              flag_z
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                flag_n_q, flag_n_d;
    logic                flag_z_q, flag_z_d;
    logic [DATA_W-1:0]   add_sum;
    logic                cla_cout_unused;

    CLA_32bit u_cla (
        .a    (acc_q),
        .b    (mcand_q),
        .sel  (1'b0),
        .Cin  (1'b0),
        .sum  (add_sum),
        .Cout (cla_cout_unused)
    );

    // Next-state and datapath; busy/done/result are precomputed so the outputs come straight from flops.
    always_comb begin
        logic last;
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        last     = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_d    = accumulate ? op_c : {DATA_W{1'b0}};
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        count_d  = {CNT_W{1'b0}};
                        busy_d   = 1'b1;
                        state_d  = ITER;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                ITER: begin
                    if (mplier_q[0]) begin
                        acc_d = add_sum;
                    end else begin
                        acc_d = acc_q;
                    end
                    mcand_d  = {mcand_q[DATA_W-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
                    count_d  = count_q + CNT_ONE;
                    last     = (count_q == CNT_LAST)
                             || ((EARLY_TERM == 1'b1) && (mplier_d == {DATA_W{1'b0}}));
                    if (last) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = acc_d;
                        flag_n_d = acc_d[DATA_W-1];
                        flag_z_d = (acc_d == {DATA_W{1'b0}});
                    end else begin
                        state_d  = ITER;
                        busy_d   = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= {DATA_W{1'b0}};
            mcand_q  <= {DATA_W{1'b0}};
            mplier_q <= {DATA_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {DATA_W{1'b0}};
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flag_n = flag_n_q;
    assign flag_z = flag_z_q;

endmodule
